// File: rtl/inst_fetch_unit_if.sv
// Instruction-ROM request/response bus between the fetch unit (master) and the ROM (slave).
interface inst_fetch_unit_if;
  logic        rom_cs;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_stall;

  modport master (
    output rom_cs,
    output rom_addr,
    input  rom_data,
    input  rom_stall
  );

  modport slave (
    input  rom_cs,
    input  rom_addr,
    output rom_data,
    output rom_stall
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// IF stage: PC, ROM request handshake and IF/ID register.
// Optional misaligned-redirect trap enabled by defining IF_ALIGN_CHECK_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_if_rst,
  input  logic                   i_if_en,
  input  logic                   i_id_rst,
  input  logic                   i_id_en,
  input  logic [2:0]             i_pc_src,
  input  logic [31:0]            i_jump_target,
  input  logic [31:0]            i_branch_target,
  input  logic [31:0]            i_reg_target,
  input  logic [31:0]            i_exc_target,
  inst_fetch_unit_if.master      rom,
  output logic                   o_fetch_stall,
  output logic [31:0]            o_inst_id,
  output logic [31:0]            o_pc_id,
  output logic                   o_valid_id,
  output logic                   o_addr_err,
  output logic [31:0]            o_badvaddr
);

  typedef enum logic [1:0] {StIdle, StFetch, StDiscard, StHold} state_e;

  state_e      r_state;
  logic [31:0] r_pc, r_req_addr, r_hold_buf, r_hold_pc;
  logic [31:0] r_inst_id, r_pc_id;
  logic        r_valid_id;

  logic        w_redirect, w_fetch, w_hold, w_both_en, w_deliver;
  logic [31:0] w_tgt_raw, w_target, w_next_seq, w_adv, w_del_inst, w_del_pc;

  always_comb begin
    w_redirect = 1'b0;
    w_tgt_raw  = i_jump_target;
    case (i_pc_src)
      3'd1:    begin w_tgt_raw = i_jump_target;   w_redirect = i_if_en; end
      3'd2:    begin w_tgt_raw = i_branch_target; w_redirect = i_if_en; end
      3'd3:    begin w_tgt_raw = i_reg_target;    w_redirect = i_if_en; end
      3'd4:    begin w_tgt_raw = i_exc_target;    w_redirect = i_if_en; end
      default: ;
    endcase
  end

`ifdef IF_ALIGN_CHECK_EN
  logic        w_misalign;
  logic        r_addr_err;
  logic [31:0] r_badvaddr;

  assign w_misalign = w_redirect & (w_tgt_raw[1:0] != 2'b00);
  assign w_target   = w_misalign ? EXC_VECTOR : w_tgt_raw;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr_err <= 1'b0;
      r_badvaddr <= 32'h0;
    end else begin
      r_addr_err <= w_misalign & ~i_if_rst;
      if (w_misalign && !i_if_rst) r_badvaddr <= w_tgt_raw;
    end
  end

  assign o_addr_err = r_addr_err;
  assign o_badvaddr = r_badvaddr;
`else
  logic w_unused;
  assign w_unused   = ^{EXC_VECTOR, w_tgt_raw[1:0]};
  assign w_target   = {w_tgt_raw[31:2], 2'b00};
  assign o_addr_err = 1'b0;
  assign o_badvaddr = 32'h0;
`endif

  assign w_fetch    = (r_state == StFetch);
  assign w_hold     = (r_state == StHold);
  assign w_both_en  = i_if_en & i_id_en;
  assign w_next_seq = r_pc + 32'd4;
  assign w_adv      = w_redirect ? w_target : w_next_seq;
  // A word reaches ID from the ROM directly or from the hold buffer; if_rst suppresses both.
  assign w_deliver  = ~i_if_rst & w_both_en & ((w_fetch & ~rom.rom_stall) | w_hold);
  assign w_del_inst = w_hold ? r_hold_buf : rom.rom_data;
  assign w_del_pc   = w_hold ? r_hold_pc : r_req_addr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_hold_buf <= 32'h0;
      r_hold_pc  <= 32'h0;
      r_inst_id  <= NOP_INST;
      r_pc_id    <= 32'h0;
      r_valid_id <= 1'b0;
    end else begin
      if (i_id_rst || (i_id_en && !w_deliver)) begin
        r_inst_id  <= NOP_INST;
        r_pc_id    <= 32'h0;
        r_valid_id <= 1'b0;
      end else if (w_deliver) begin
        r_inst_id  <= w_del_inst;
        r_pc_id    <= w_del_pc;
        r_valid_id <= 1'b1;
      end

      if (i_if_rst) begin
        r_pc <= RESET_PC;
        // An access already stalled must be allowed to complete before reissuing.
        if (w_fetch && rom.rom_stall) begin
          r_state <= StDiscard;
        end else begin
          r_req_addr <= RESET_PC;
          r_state    <= StIdle;
        end
      end else begin
        case (r_state)
          StIdle: begin
            r_pc       <= w_redirect ? w_target : r_pc;
            r_req_addr <= w_redirect ? w_target : r_pc;
            r_state    <= StFetch;
          end
          StFetch: begin
            if (!rom.rom_stall) begin
              if (w_both_en || w_redirect) begin
                r_pc       <= w_adv;
                r_req_addr <= w_adv;
              end else begin
                r_hold_buf <= rom.rom_data;
                r_hold_pc  <= r_req_addr;
                r_state    <= StHold;
              end
            end else if (w_redirect) begin
              r_pc    <= w_target;
              r_state <= StDiscard;
            end
          end
          StDiscard: begin
            if (w_redirect) r_pc <= w_target;
            if (!rom.rom_stall) begin
              r_req_addr <= w_redirect ? w_target : r_pc;
              r_state    <= StFetch;
            end
          end
          StHold: begin
            if (w_both_en || w_redirect) begin
              r_pc       <= w_adv;
              r_req_addr <= w_adv;
              r_state    <= StFetch;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign rom.rom_cs   = w_fetch | (r_state == StDiscard);
  assign rom.rom_addr = r_req_addr;
  assign o_fetch_stall = rom.rom_cs & rom.rom_stall;
  assign o_inst_id    = r_inst_id;
  assign o_pc_id      = r_pc_id;
  assign o_valid_id   = r_valid_id;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios, then randomized traffic
// checked against an architectural next-instruction model.
module tb_inst_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0008;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, if_rst, if_en, id_rst, id_en, stall;
  logic [2:0]  pc_src;
  logic [31:0] jt, bt, rt, et;
  logic        fetch_stall, valid_id, addr_err;
  logic [31:0] inst_id, pc_id, badvaddr;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  inst_fetch_unit_if rom_bus ();
  assign rom_bus.rom_stall = stall;
  // Data is only meaningful on a completing access; otherwise drive a recognisably wrong word.
  assign rom_bus.rom_data  = (rom_bus.rom_cs && !stall) ? rom_word(rom_bus.rom_addr)
                                                        : ~rom_word(rom_bus.rom_addr);

  inst_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .NOP_INST   (NOP_INST),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_if_rst        (if_rst),
    .i_if_en         (if_en),
    .i_id_rst        (id_rst),
    .i_id_en         (id_en),
    .i_pc_src        (pc_src),
    .i_jump_target   (jt),
    .i_branch_target (bt),
    .i_reg_target    (rt),
    .i_exc_target    (et),
    .rom             (rom_bus),
    .o_fetch_stall   (fetch_stall),
    .o_inst_id       (inst_id),
    .o_pc_id         (pc_id),
    .o_valid_id      (valid_id),
    .o_addr_err      (addr_err),
    .o_badvaddr      (badvaddr)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: address the next delivered instruction must carry, plus the IF/ID contents.
  logic [31:0] exp_next, exp_bad, m_inst, m_pc;
  logic        m_valid;
  int          gap;
  logic        prev_cs_stall, prev_if_rst;
  logic [31:0] prev_addr;

  logic        a_rst_n, a_if_rst, a_if_en, a_id_rst, a_id_en, a_stall, a_cs_stall, a_redir;
  logic [2:0]  a_src;
  logic [31:0] a_addr, a_raw;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task step();
    #1;
    if (rst_n) begin
      chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, rom_bus.rom_cs & stall});
      if (prev_cs_stall && !prev_if_rst) begin
        chk("stall_cs_held", {31'b0, rom_bus.rom_cs}, 32'd1);
        chk("stall_addr_held", rom_bus.rom_addr, prev_addr);
      end
    end
    a_rst_n = rst_n; a_if_rst = if_rst; a_if_en = if_en; a_id_rst = id_rst; a_id_en = id_en;
    a_stall = stall; a_src = pc_src; a_addr = rom_bus.rom_addr;
    a_cs_stall = rom_bus.rom_cs & stall;
    case (pc_src)
      3'd1: a_raw = jt;
      3'd2: a_raw = bt;
      3'd3: a_raw = rt;
      3'd4: a_raw = et;
      default: a_raw = 32'h0;
    endcase
    a_redir = if_en && (pc_src >= 3'd1) && (pc_src <= 3'd4);
    @(posedge clk);
    #1;
    if (!a_rst_n) begin
      exp_next = RESET_PC; exp_bad = 32'h0; gap = 0;
      m_inst = NOP_INST; m_pc = 32'h0; m_valid = 1'b0;
      prev_cs_stall = 1'b0; prev_if_rst = 1'b0;
      return;
    end
    if (!a_id_en && !a_id_rst) begin
      chk("ifid_hold_valid", {31'b0, valid_id}, {31'b0, m_valid});
      chk("ifid_hold_inst", inst_id, m_inst);
      if (m_valid) chk("ifid_hold_pc", pc_id, m_pc);
    end else if (valid_id) begin
      chk("deliver_allowed", {31'b0, a_if_en & ~a_if_rst & ~a_id_rst}, 32'd1);
      chk("pc_id", pc_id, exp_next);
      chk("inst_id", inst_id, rom_word(exp_next));
      m_inst = rom_word(exp_next); m_pc = exp_next; m_valid = 1'b1;
      exp_next = exp_next + 32'd4;
      gap = 0;
    end else begin
      chk("bubble_inst", inst_id, NOP_INST);
      if (a_id_rst) chk("flush_pc", pc_id, 32'h0);
      m_inst = NOP_INST; m_valid = 1'b0;
      if (a_if_en && a_id_en && !a_stall && !a_if_rst) gap++;
    end
    exp_err = 1'b0;
    if (a_if_rst) begin
      exp_next = RESET_PC; gap = 0;
    end else if (a_redir) begin
      gap = 0;
`ifdef IF_ALIGN_CHECK_EN
      if (a_raw[1:0] != 2'b00) begin
        exp_next = EXC_VECTOR; exp_err = 1'b1; exp_bad = a_raw;
      end else begin
        exp_next = a_raw;
      end
`else
      exp_next = {a_raw[31:2], 2'b00};
`endif
    end
    chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
    chk("badvaddr", badvaddr, exp_bad);
    chk("progress", {31'b0, gap <= 2}, 32'd1);
    prev_cs_stall = a_cs_stall; prev_addr = a_addr; prev_if_rst = a_if_rst;
  endtask

  initial begin
    rst_n = 1'b0; if_rst = 1'b0; if_en = 1'b1; id_rst = 1'b0; id_en = 1'b1; stall = 1'b0;
    pc_src = 3'd0; jt = 32'h0; bt = 32'h0; rt = 32'h0; et = 32'h0;
    prev_cs_stall = 1'b0; prev_if_rst = 1'b0; prev_addr = 32'h0;
    step(); step();
    chk("rst_rom_cs", {31'b0, rom_bus.rom_cs}, 32'd0);
    chk("rst_rom_addr", rom_bus.rom_addr, RESET_PC);
    chk("rst_fetch_stall", {31'b0, fetch_stall}, 32'd0);
    chk("rst_inst_id", inst_id, NOP_INST);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_valid_id", {31'b0, valid_id}, 32'd0);
    chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
    chk("rst_badvaddr", badvaddr, 32'h0);

    // Back-to-back stream from reset.
    rst_n = 1'b1;
    step();
    chk("s1_cs", {31'b0, rom_bus.rom_cs}, 32'd1);
    chk("s1_addr", rom_bus.rom_addr, 32'h0);
    chk("s1_valid", {31'b0, valid_id}, 32'd0);
    step();
    chk("s2_valid", {31'b0, valid_id}, 32'd1);
    chk("s2_pc", pc_id, 32'h0);
    chk("s2_addr", rom_bus.rom_addr, 32'h4);
    step();
    chk("s3_pc", pc_id, 32'h4);
    chk("s3_addr", rom_bus.rom_addr, 32'h8);

    // Three ROM wait states at address 8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_valid", {31'b0, valid_id}, 32'd0);
      chk("ws_addr", rom_bus.rom_addr, 32'h8);
    end
    stall = 1'b0;
    step();
    chk("ws_done_pc", pc_id, 32'h8);
    chk("ws_done_addr", rom_bus.rom_addr, 32'hC);

    // Branch while the access at 12 is stalled.
    stall = 1'b1; pc_src = 3'd2; bt = 32'h40;
    step();
    chk("br_addr_held", rom_bus.rom_addr, 32'hC);
    pc_src = 3'd0;
    step();
    stall = 1'b0;
    step();
    chk("br_drop_valid", {31'b0, valid_id}, 32'd0);
    chk("br_new_addr", rom_bus.rom_addr, 32'h40);
    step();
    chk("br_pc", pc_id, 32'h40);

    // Downstream stall with a word already returned.
    if_en = 1'b0; id_en = 1'b0;
    step();
    chk("hold_cs0", {31'b0, rom_bus.rom_cs}, 32'd0);
    step();
    chk("hold_cs1", {31'b0, rom_bus.rom_cs}, 32'd0);
    chk("hold_pc", pc_id, 32'h40);
    if_en = 1'b1; id_en = 1'b1;
    step();
    chk("hold_rel_pc", pc_id, 32'h44);
    chk("hold_rel_addr", rom_bus.rom_addr, 32'h48);
    step();
    chk("hold_next_pc", pc_id, 32'h48);

    // Flush together with a jump.
    id_rst = 1'b1; pc_src = 3'd1; jt = 32'h100;
    step();
    chk("fl_valid", {31'b0, valid_id}, 32'd0);
    chk("fl_addr", rom_bus.rom_addr, 32'h100);
    id_rst = 1'b0; pc_src = 3'd0;
    step();
    chk("fl_pc", pc_id, 32'h100);
`ifdef IF_ALIGN_CHECK_EN
    pc_src = 3'd1; jt = 32'h102;
    step();
    chk("mis_err", {31'b0, addr_err}, 32'd1);
    chk("mis_bad", badvaddr, 32'h102);
    chk("mis_addr", rom_bus.rom_addr, EXC_VECTOR);
    pc_src = 3'd0;
    step();
    chk("mis_err_pulse", {31'b0, addr_err}, 32'd0);
`endif

    // PC wrap at the top of the address space.
    pc_src = 3'd1; jt = 32'hFFFF_FFF8;
    step();
    pc_src = 3'd0;
    step();
    chk("wrap_pc0", pc_id, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", pc_id, 32'hFFFF_FFFC);
    chk("wrap_addr", rom_bus.rom_addr, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      stall  = ($urandom_range(0, 9) < 3);
      if_en  = ($urandom_range(0, 9) != 0);
      id_en  = ($urandom_range(0, 9) != 0);
      pc_src = ($urandom_range(0, 9) < 2) ? 3'($urandom_range(1, 7)) : 3'd0;
      jt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                       : 32'($urandom_range(0, 4095));
      bt = 32'($urandom_range(0, 4095));
      rt = 32'($urandom_range(0, 4095));
      et = 32'($urandom_range(0, 4095));
      id_rst = ($urandom_range(0, 29) == 0);
      if (id_rst) begin
        if_en  = 1'b1;
        pc_src = 3'($urandom_range(1, 4));
      end
      if_rst = ($urandom_range(0, 49) == 0);
      step();
    end
    if_rst = 1'b0; id_rst = 1'b0; pc_src = 3'd0; stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch (IF) stage directly upstream of the ID-stage controller.
- Owns the PC register, the instruction-ROM request handshake and the IF/ID pipeline register.
- Consumes pc_src, the if_*/id_* stage controls and the redirect targets from ID.
- Produces the instruction word and PC that the controller decodes.
- Sustains one fetch per cycle with a zero-wait ROM. Absorbs ROM wait states and downstream stalls without losing or duplicating instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset and on if_rst
NOP_INST, 32'h0000_0000, instruction word driven into ID on a bubble
EXC_VECTOR, 32'h0000_0008, redirect address for a misaligned target (used only with IF_ALIGN_CHECK_EN)

Ports:
clk  in  1  main clock
rst_n  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low
if_rst  in  1  IF stage reset: PC <= RESET_PC, drop any access in flight
if_en  in  1  IF stage enable (PC advance / redirect acceptance)
id_rst  in  1  IF/ID register flush
id_en  in  1  IF/ID register load enable
pc_src  in  3  0 NEXT, 1 JUMP, 2 BRANCH, 3 FWD_DATA (jr), 4 EXC; 5-7 are treated as NEXT
jump_target  in  32  target for pc_src=1
branch_target  in  32  target for pc_src=2
reg_target  in  32  target for pc_src=3
exc_target  in  32  target for pc_src=4
rom_cs  out  1  ROM request
rom_addr  out  32  ROM word address, byte-addressed
rom_data  in  32  ROM read data, valid in the cycle rom_cs=1 and rom_stall=0
rom_stall  in  1  access not yet complete
fetch_stall  out  1  rom_cs & rom_stall (to controller)
inst_id  out  32  IF/ID instruction
pc_id  out  32  PC of inst_id
valid_id  out  1  inst_id is a real instruction
addr_err  out  1  misaligned redirect pulse (optional feature)
badvaddr  out  32  offending target (optional feature)

Behaviour:
Reset (rst_n=0 at a clk edge):
- pc = req_addr = RESET_PC; state IDLE.
- rom_cs=0, rom_addr=RESET_PC, fetch_stall=0.
- inst_id=NOP_INST, pc_id=0, valid_id=0.
- addr_err=0, badvaddr=0.

Registers and derived terms:
- req_addr drives rom_addr and is held stable while rom_stall=1.
- pc is the next address to request.
- next_seq = pc+4, mod 2^32 (wraps from 32'hFFFF_FFFC to 0).
- redirect = if_en & pc_src in 1..4.
- accept = FETCH & ~rom_stall & if_en & id_en.

States:
- IDLE: rom_cs=0. Next state FETCH with req_addr=pc.
- FETCH: rom_cs=1.
  - accept: IF/ID <= {rom_data, req_addr, 1}. pc and req_addr <= redirect ? target : next_seq. Stay in FETCH. Back-to-back, latency 1 cycle from request to IF/ID.
  - ~rom_stall & ~(if_en & id_en): hold_buf <= rom_data, hold_pc <= req_addr; go to HOLD. A simultaneous redirect is still applied: pc <= target, hold dropped, go to FETCH.
  - rom_stall & redirect: pc <= target, req_addr unchanged; go to DISCARD.
  - rom_stall, no redirect: IF/ID loads a bubble if id_en; pc holds.
- DISCARD: rom_cs=1 at req_addr until rom_stall=0. The returned word is dropped and never reaches ID. Then req_addr <= pc; go to FETCH. Later redirects update pc only.
- HOLD: rom_cs=0.
  - if_en & id_en: IF/ID <= {hold_buf, hold_pc, 1}; pc and req_addr <= redirect ? target : next_seq; go to FETCH.
  - redirect alone: drop hold; pc and req_addr <= target; go to FETCH.

Precedence and bubbles:
- id_rst beats id_en: IF/ID <= {NOP_INST, 0, 0}. A word accepted in the same cycle is consumed and discarded.
- if_rst beats every state action except rst_n. It behaves as a redirect to RESET_PC: from FETCH with rom_stall=1 go to DISCARD, otherwise go to IDLE.
- IF/ID bubble whenever id_en=1 and no word is delivered.
- id_en=0 holds IF/ID unchanged.

Optional Feature:
Macro IF_ALIGN_CHECK_EN.
- Defined: a redirect target with [1:0]!=0 sets addr_err=1 for exactly one cycle, badvaddr <= target, and uses EXC_VECTOR in place of the target. badvaddr holds until the next error or reset.
- Undefined: target[1:0] is forced to 0; addr_err=0 and badvaddr=0 constantly.

Test Plan:
- Reset then rom_stall=0, all enables 1 → rom_addr 0,4,8,… on consecutive cycles; valid_id=1 from cycle 2; pc_id=0,4,8.
- rom_stall=1 for 3 cycles at addr 8 → fetch_stall=1 for those cycles, 3 bubbles (valid_id=0), rom_addr stays 8, then inst@8 delivered once.
- pc_src=2, branch_target=32'h40 while the access at 12 is stalled → word@12 dropped, next rom_addr=32'h40, no instruction with pc_id=12 ever valid.
- if_en=id_en=0 for 2 cycles with a word returned → rom_cs=0 in HOLD, IF/ID unchanged, word delivered once when enables return, no refetch.
- id_rst=1 with pc_src=1, jump_target=32'h100 → valid_id=0, inst_id=NOP_INST, next rom_addr=32'h100; with IF_ALIGN_CHECK_EN, jump_target=32'h102 → addr_err 1 cycle, badvaddr=32'h102, rom_addr=EXC_VECTOR.
